// File: rtl/instr_encoder.sv
// RISC-V I/S/B/J instruction encoder with range/alignment checking.
// Encoded beats are queued in a 2-entry FIFO, and the block counts delivered and erroneous beats.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [1:0]  out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4094;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048574;

    logic [31:0] encInstr;
    logic        rangeErr;
    logic        alignErr;
    logic signed [31:0] immS;

    logic [31:0] memInstr_q [2];
    logic [1:0]  memErr_q   [2];
    logic        wrPtr_q, wrPtr_d;
    logic        rdPtr_q, rdPtr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] encCount_q, encCount_d;
    logic [7:0]  errCount_q, errCount_d;
    logic        accept;
    logic        deliver;

    assign immS = $signed(in_imm);

    // Out-of-range immediates still encode their truncated bits; only the error flag differs.
    always_comb begin
        encInstr = '0;
        rangeErr = 1'b0;
        alignErr = 1'b0;
        case (in_fmt)
            FMT_I: begin
                encInstr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                rangeErr = (immS < IS_MIN) || (immS > IS_MAX);
            end
            FMT_S: begin
                encInstr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                rangeErr = (immS < IS_MIN) || (immS > IS_MAX);
            end
            FMT_B: begin
                encInstr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                rangeErr = (immS < B_MIN) || (immS > B_MAX);
                alignErr = in_imm[0];
            end
            default: begin
                encInstr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                rangeErr = (immS < J_MIN) || (immS > J_MAX);
                alignErr = in_imm[0];
            end
        endcase
    end

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    assign out_instr = out_valid ? memInstr_q[rdPtr_q] : 32'd0;
    assign out_err   = out_valid ? memErr_q[rdPtr_q]   : 2'd0;
    assign enc_count = encCount_q;
    assign err_count = errCount_q;

    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        encCount_d = encCount_q;
        errCount_d = errCount_q;
        if (accept) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (deliver) begin
            rdPtr_d    = ~rdPtr_q;
            encCount_d = encCount_q + 16'd1;
            if ((memErr_q[rdPtr_q] != 2'd0) && (errCount_q != 8'hFF)) begin
                errCount_d = errCount_q + 8'd1;
            end
        end
        if (accept && !deliver) begin
            count_d = count_q + 2'd1;
        end else if (deliver && !accept) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q       <= 1'b0;
            rdPtr_q       <= 1'b0;
            count_q       <= 2'd0;
            encCount_q    <= 16'd0;
            errCount_q    <= 8'd0;
            memInstr_q[0] <= 32'd0;
            memInstr_q[1] <= 32'd0;
            memErr_q[0]   <= 2'd0;
            memErr_q[1]   <= 2'd0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            encCount_q <= encCount_d;
            errCount_q <= errCount_d;
            if (accept) begin
                memInstr_q[wrPtr_q] <= encInstr;
                memErr_q[wrPtr_q]   <= {alignErr, rangeErr};
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-002 in_valid input 1: request beat present; in_ready output 1: encoder accepts beat this cycle.
REQ-003 in_fmt input 2: 00 I, 01 S, 10 B, 11 J (same code as the extend unit's immsrc).
REQ-004 in_opcode input 7, in_funct3 input 3, in_rd input 5, in_rs1 input 5, in_rs2 input 5: instruction fields.
REQ-005 in_imm input 32: signed two's-complement immediate (byte offset for B/J).
REQ-006 out_valid output 1, out_ready input 1: output handshake; out_instr output 32: encoded word; out_err output 2: bit0 range error, bit1 misalignment.
REQ-007 enc_count output 16: beats delivered; err_count output 8: beats delivered with out_err != 0.

Function
REQ-008 Transfer SHALL occur on a rising edge with valid and ready both high, on either port.
REQ-009 Encoding SHALL be: I {imm[11:0],rs1,funct3,rd,opcode}; S {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-010 Unused fields SHALL be ignored: rs2 for I and J; rd for S and B; funct3 and rs1 for J.
REQ-011 Legal ranges: I/S -2048..2047; B -4096..4094; J -1048576..1048574; out-of-range SHALL set out_err[0] and still encode truncated bits per REQ-009.
REQ-012 For B/J, in_imm[0]=1 SHALL set out_err[1]; bit 0 is dropped; I/S never set out_err[1].
REQ-013 Round-trip: for any error-free beat, sign-extending out_instr[31:7] with immsrc=in_fmt SHALL reproduce in_imm exactly.
REQ-014 Encoded beats SHALL pass through a 2-entry FIFO in strict acceptance order; in_ready SHALL be high iff occupancy < 2, combinational from occupancy only.
REQ-015 Latency: a beat accepted into an empty FIFO SHALL present out_valid=1 with its out_instr/out_err on the next cycle.
REQ-016 Simultaneous accept and deliver SHALL leave occupancy unchanged; at occupancy 2 no accept occurs, and in_ready rises the cycle after a delivery.
REQ-017 out_instr/out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 out_instr SHALL read 0 and out_err 0 when out_valid=0.
REQ-019 enc_count SHALL increment on every output transfer, wrapping 0xFFFF->0x0000.
REQ-020 err_count SHALL increment on output transfers with out_err!=0, saturating at 255.
REQ-021 Occupancy pointers SHALL wrap modulo 2 without loss or duplication.

Reset
REQ-022 rst_n low SHALL immediately, without waiting for clk, clear FIFO occupancy and pointers, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
REQ-023 During and after reset in_ready SHALL be 1, since the FIFO is empty.
REQ-024 Reset asserted mid-operation SHALL discard all queued beats; no queued beat appears after release.
REQ-025 The first accept SHALL occur on the first rising edge with rst_n high.

Verification
REQ-026 I-type: imm=0xFFFFF800, rd=5, rs1=6, funct3=0, opcode=0x13 -> out_instr=0x80030293, out_err=00, one cycle later.
REQ-027 S-type: imm=0xFFFFF80A, rs2=2, rs1=3, funct3=2, opcode=0x23 -> out_instr=0x8021A523, out_err=00.
REQ-028 B-type: imm=3 -> out_err=10; imm=4096 -> out_err=01; err_count=2 after both delivered.
REQ-029 Back-pressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0; raise out_ready -> beats delivered in order, third accepted.
REQ-030 Reset with 2 beats queued -> out_valid=0, in_ready=1, enc_count=0 without a clock edge; no stale beat after release.
REQ-031 Counters: 300 erroneous beats -> err_count=255; 65537 beats -> enc_count=1.
